// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rename_pkg
//  Description : Shared rename-stage definitions. The free list, the map
//                table and the rename/register-read pipeline registers use
//                these constants and types.
//                  NPHYS / NARCH : physical / architectural register counts
//                  PHYS_W        : physical register number width
//                  FL_DEPTH      : free-list capacity (NPHYS - NARCH)
//                  preg_t        : physical register number
//                  flptr_t       : free-list pointer (index plus wrap bit)
//  Revision    : 1.0 - initial release
// ============================================================================
package rename_pkg;

    localparam int NPHYS    = 64;
    localparam int NARCH    = 32;
    localparam int PHYS_W   = 6;
    localparam int FL_DEPTH = NPHYS - NARCH;

    typedef logic [PHYS_W-1:0] preg_t;
    typedef logic [5:0]        flptr_t;

    // Number of set bits in a pair of per-slot request flags (0..2).
    function automatic logic [1:0] count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/free_list_ram.sv
`default_nettype none
// ============================================================================
//  Module      : free_list_ram
//  Description : Slot storage for the physical-register free list.
//                DEPTH entries of PHYS_W bits, two combinational read ports,
//                two synchronous write ports. Reset loads slot i with
//                DEPTH + i, i.e. the physical registers not initially mapped.
//  Ports       : clk, rst                     - clock, sync active-high reset
//                rd_addr0_i / rd_data0_o      - read port 0
//                rd_addr1_i / rd_data1_o      - read port 1
//                we0_i, wr_addr0_i, wr_data0_i - write port 0
//                we1_i, wr_addr1_i, wr_data1_i - write port 1
//  Revision    : 1.0 - initial release
// ============================================================================
module free_list_ram #(
    parameter int PHYS_W = 6,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd_addr0_i,
    output logic [PHYS_W-1:0] rd_data0_o,
    input  logic [AW-1:0]     rd_addr1_i,
    output logic [PHYS_W-1:0] rd_data1_o,
    input  logic              we0_i,
    input  logic [AW-1:0]     wr_addr0_i,
    input  logic [PHYS_W-1:0] wr_data0_i,
    input  logic              we1_i,
    input  logic [AW-1:0]     wr_addr1_i,
    input  logic [PHYS_W-1:0] wr_data1_i
);

    logic [PHYS_W-1:0] mem_q [DEPTH];

    assign rd_data0_o = mem_q[rd_addr0_i];
    assign rd_data1_o = mem_q[rd_addr1_i];

    // The two write addresses are always consecutive tail slots, so they
    // never collide; port 1 is still written last for determinism.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PHYS_W'(DEPTH + i);
            end
        end else begin
            if (we0_i) mem_q[wr_addr0_i] <= wr_data0_i;
            if (we1_i) mem_q[wr_addr1_i] <= wr_data1_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
//  Module      : free_list
//  Description : Physical-register free list for the 2-wide rename stage.
//                Hands out up to two free registers per cycle (zero-latency
//                combinational lookup from the speculative head), takes back
//                up to two superseded registers per cycle from commit, and on
//                recover rolls the speculative head back to the committed
//                head (after applying same-cycle commits).
//  Ports       : clk, rst                 - clock, sync active-high reset
//                stall, recover           - rename stall, pipeline flush
//                alloc_req1/2             - rename slot 1/2 needs a register
//                rd1p, rd2p               - allocated registers for slot 1/2
//                alloc_ok                 - enough free entries for request
//                commit1/2, commit_old1/2 - retiring slot frees old mapping
//                free_count               - entries available to allocate
//  Revision    : 1.0 - initial release
// ============================================================================
module free_list #(
    parameter int PHYS_W = 6,
    parameter int DEPTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       recover,
    input  logic                       alloc_req1,
    input  logic                       alloc_req2,
    output logic [PHYS_W-1:0]          rd1p,
    output logic [PHYS_W-1:0]          rd2p,
    output logic                       alloc_ok,
    input  logic                       commit1,
    input  logic                       commit2,
    input  logic [PHYS_W-1:0]          commit_old1,
    input  logic [PHYS_W-1:0]          commit_old2,
    output logic [$clog2(DEPTH)+1:0]   free_count
);

    import rename_pkg::*;

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    // Pointers carry a wrap bit above the slot index so full (difference
    // DEPTH) and empty (difference 0) are distinguishable.
    logic [PTR_W-1:0] spec_head_q,   spec_head_d;
    logic [PTR_W-1:0] commit_head_q, commit_head_d;
    logic [PTR_W-1:0] tail_q,        tail_d;

    logic [1:0]       w_nreq;
    logic [1:0]       w_ncommit;
    logic [PTR_W-1:0] w_avail;
    logic [PTR_W-1:0] w_live;
    logic             w_fire;
    logic [AW-1:0]    w_rd_addr0;
    logic [AW-1:0]    w_rd_addr1;
    logic [AW-1:0]    w_wr_addr0;
    logic [AW-1:0]    w_wr_addr1;

    assign w_nreq    = count2(alloc_req1, alloc_req2);
    assign w_ncommit = count2(commit1, commit2);

    // Uses the registered tail, so a register freed this cycle is never
    // counted (or handed out) until the next one.
    assign w_avail    = tail_q - spec_head_q;
    assign free_count = {1'b0, w_avail};
    assign alloc_ok   = (free_count >= (PTR_W + 1)'(w_nreq));
    assign w_fire     = alloc_ok & ~stall & ~recover;

    // Slot 2 takes the entry after slot 1 only when slot 1 is also taking one.
    assign w_rd_addr0 = spec_head_q[AW-1:0];
    assign w_rd_addr1 = spec_head_q[AW-1:0] + AW'(alloc_req1);

    // A lone commit2 writes at the tail itself.
    assign w_wr_addr0 = tail_q[AW-1:0];
    assign w_wr_addr1 = tail_q[AW-1:0] + AW'(commit1);

    free_list_ram #(
        .PHYS_W (PHYS_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .rd_addr0_i (w_rd_addr0),
        .rd_data0_o (rd1p),
        .rd_addr1_i (w_rd_addr1),
        .rd_data1_o (rd2p),
        .we0_i      (commit1),
        .wr_addr0_i (w_wr_addr0),
        .wr_data0_i (commit_old1),
        .we1_i      (commit2),
        .wr_addr1_i (w_wr_addr1),
        .wr_data1_i (commit_old2)
    );

    always_comb begin
        commit_head_d = commit_head_q + PTR_W'(w_ncommit);
        tail_d        = tail_q + PTR_W'(w_ncommit);
        spec_head_d   = spec_head_q;
        if (recover) begin
            // Same-cycle commits are already folded into commit_head_d.
            spec_head_d = commit_head_d;
        end else if (w_fire) begin
            spec_head_d = spec_head_q + PTR_W'(w_nreq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= PTR_W'(DEPTH);
        end else begin
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
        end
    end

    // Every committed allocation returns exactly one register, so the
    // committed window always spans the full list capacity.
    assign w_live = tail_q - commit_head_q;

    a_window_full : assert property (@(posedge clk) disable iff (rst)
        w_live == PTR_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : tb_free_list
//  Description : Self-checking bench for free_list. A queue model of the
//                committed window predicts outputs; expected values are
//                queued when stimulus is driven and popped/compared once
//                the outputs settle. Directed scenarios followed by a long
//                random alloc/commit/recover run with a mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_free_list;

    import rename_pkg::*;

    localparam int K_FC  = 0;
    localparam int K_OK  = 1;
    localparam int K_RD1 = 2;
    localparam int K_RD2 = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0, recover = 1'b0;
    logic       alloc_req1 = 1'b0, alloc_req2 = 1'b0;
    logic       commit1 = 1'b0, commit2 = 1'b0;
    preg_t      commit_old1 = '0, commit_old2 = '0;
    preg_t      rd1p, rd2p;
    logic       alloc_ok;
    logic [6:0] free_count;

    free_list #(.PHYS_W(6), .DEPTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .recover     (recover),
        .alloc_req1  (alloc_req1),
        .alloc_req2  (alloc_req2),
        .rd1p        (rd1p),
        .rd2p        (rd2p),
        .alloc_ok    (alloc_ok),
        .commit1     (commit1),
        .commit2     (commit2),
        .commit_old1 (commit_old1),
        .commit_old2 (commit_old2),
        .free_count  (free_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    typedef struct {
        int kind;
        int val;
    } exp_t;
    exp_t sb_q[$];

    // Model: m_free holds the committed window (commit_head..tail) in order;
    // its first m_spec entries are speculatively allocated.
    preg_t m_free[$];
    preg_t m_ret[$];
    int    m_spec;
    bit    m_live[64];
    bit    rand_mode = 1'b0;
    bit    m_fire;
    preg_t m_e1, m_e2;

    task automatic model_reset();
        m_free.delete();
        m_ret.delete();
        for (int i = 0; i < 32; i++) begin
            m_free.push_back(preg_t'(32 + i));
            m_ret.push_back(preg_t'(i));
            m_live[i]      = 1'b1;
            m_live[32 + i] = 1'b0;
        end
        m_spec = 0;
        m_fire = 1'b0;
    endtask

    task automatic drive(input bit r1, input bit r2, input bit st, input bit rc,
                         input bit c1, input bit c2, input preg_t o1, input preg_t o2);
        int    nreq, fc;
        bit    ok;
        exp_t  e;
        logic [5:0] win;
        alloc_req1 = r1; alloc_req2 = r2; stall = st; recover = rc;
        commit1 = c1; commit2 = c2; commit_old1 = o1; commit_old2 = o2;
        #1;
        nreq = int'(r1) + int'(r2);
        fc   = 32 - m_spec;
        ok   = (fc >= nreq);
        m_fire = ok && !st && !rc;
        sb_q.push_back('{K_FC, fc});
        sb_q.push_back('{K_OK, int'(ok)});
        if (ok && r1) begin
            m_e1 = m_free[m_spec];
            sb_q.push_back('{K_RD1, int'(m_e1)});
        end
        if (ok && r2) begin
            m_e2 = r1 ? m_free[m_spec + 1] : m_free[m_spec];
            sb_q.push_back('{K_RD2, int'(m_e2)});
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_FC:    check_val("free_count", int'(free_count), e.val);
                K_OK:    check_val("alloc_ok", int'(alloc_ok), e.val);
                K_RD1:   check_val("rd1p", int'(rd1p), e.val);
                default: check_val("rd2p", int'(rd2p), e.val);
            endcase
        end
        if (m_fire && r1) check_val("rd1p_not_live", int'(m_live[rd1p]), 0);
        if (m_fire && r2) check_val("rd2p_not_live", int'(m_live[rd2p]), 0);
        if (!rst) begin
            win = dut.tail_q - dut.commit_head_q;
            check_val("window", int'(win), 32);
        end
    endtask

    task automatic commit_one(input preg_t old);
        preg_t newr;
        newr = m_free.pop_front();
        m_spec--;
        if (rand_mode) begin
            void'(m_ret.pop_front());
            m_ret.push_back(newr);
        end
        m_live[old] = 1'b0;
        m_free.push_back(old);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_fire) begin
                if (alloc_req1) m_live[m_e1] = 1'b1;
                if (alloc_req2) m_live[m_e2] = 1'b1;
                m_spec += int'(alloc_req1) + int'(alloc_req2);
            end
            if (commit1) commit_one(commit_old1);
            if (commit2) commit_one(commit_old2);
            if (recover) begin
                for (int i = 0; i < m_spec; i++) m_live[m_free[i]] = 1'b0;
                m_spec = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d checks", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int    k;
        bit    r1, r2, st, rc, c1, c2;
        preg_t o1, o2;

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state (stalled so nothing is taken).
        drive(1, 1, 1, 0, 0, 0, '0, '0);
        check_val("rst_fc", int'(free_count), 32);
        check_val("rst_ok", int'(alloc_ok), 1);
        check_val("rst_rd1", int'(rd1p), 32);
        check_val("rst_rd2", int'(rd2p), 33);
        tick();

        // Drain: 15 pairs, one single, then the boundary cases.
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 0, 0, 0, 0, '0, '0);
            check_val("seq_rd1", int'(rd1p), 32 + 2 * i);
            check_val("seq_rd2", int'(rd2p), 33 + 2 * i);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, '0, '0);
        check_val("seq_rd1_62", int'(rd1p), 62);
        tick();
        drive(1, 1, 0, 0, 0, 0, '0, '0);
        check_val("fc1_req2_ok", int'(alloc_ok), 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, '0, '0);
        check_val("fc1_head_kept", int'(free_count), 1);
        check_val("req2_only_rd2", int'(rd2p), 63);
        check_val("req2_only_ok", int'(alloc_ok), 1);
        tick();
        drive(1, 0, 0, 0, 0, 0, '0, '0);
        check_val("empty_ok", int'(alloc_ok), 0);
        check_val("empty_fc", int'(free_count), 0);
        tick();
        idle();
        check_val("empty_nreq0_ok", int'(alloc_ok), 1);
        tick();

        // Commit frees 5 and 7; they come back after wrap-around.
        do_reset();
        repeat (2) begin drive(1, 1, 0, 0, 0, 0, '0, '0); tick(); end
        drive(0, 0, 0, 0, 1, 1, 6'd5, 6'd7);
        tick();
        idle();
        check_val("commit_fc30", int'(free_count), 30);
        tick();
        repeat (14) begin drive(1, 1, 0, 0, 0, 0, '0, '0); tick(); end
        drive(1, 1, 0, 0, 0, 0, '0, '0);
        check_val("wrap_rd1_5", int'(rd1p), 5);
        check_val("wrap_rd2_7", int'(rd2p), 7);
        tick();

        // Recover together with commit, then stall, then a lone commit2.
        do_reset();
        repeat (3) begin drive(1, 1, 0, 0, 0, 0, '0, '0); tick(); end
        drive(1, 1, 1, 1, 1, 1, 6'd1, 6'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 0, 0, '0, '0);
            check_val("rc_fc", int'(free_count), 32);
            check_val("rc_spec_head", int'(dut.spec_head_q), 2);
            check_val("rc_commit_head", int'(dut.commit_head_q), 2);
            check_val("stall_rd1", int'(rd1p), 34);
            check_val("stall_rd2", int'(rd2p), 35);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, '0, '0);
        tick();
        drive(0, 0, 0, 0, 0, 1, '0, 6'd9);
        tick();
        idle();
        check_val("c2_tail", int'(dut.tail_q), 35);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 0, 0, 0, '0, '0);
            if (i == 15) begin
                check_val("c2_rd1_2", int'(rd1p), 2);
                check_val("c2_rd2_9", int'(rd2p), 9);
            end
            tick();
        end

        // Random traffic with a mid-run reset.
        rand_mode = 1'b1;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc == 5000) begin
                rst = 1'b1;
                drive(1, 1, 0, 0, 0, 0, '0, '0);
                tick();
                rst = 1'b0;
                drive(1, 1, 1, 0, 0, 0, '0, '0);
                check_val("midrst_fc", int'(free_count), 32);
                check_val("midrst_ok", int'(alloc_ok), 1);
                check_val("midrst_rd1", int'(rd1p), 32);
                check_val("midrst_rd2", int'(rd2p), 33);
                check_val("midrst_tail", int'(dut.tail_q), 32);
                tick();
            end
            r1 = ($urandom % 10) < 6;
            r2 = ($urandom % 10) < 6;
            st = ($urandom % 10) == 0;
            rc = ($urandom % 100) < 3;
            k  = int'($urandom % 4);
            c1 = (k == 1) || (k == 3);
            c2 = (k == 2) || (k == 3);
            if (c1 && c2 && m_spec < 2) c2 = 1'b0;
            if (m_spec < 1) begin c1 = 1'b0; c2 = 1'b0; end
            o1 = '0; o2 = '0;
            if (c1) o1 = m_ret[0];
            if (c2) o2 = c1 ? m_ret[1] : m_ret[0];
            drive(r1, r2, st, rc, c1, c2, o1, o2);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
